// File: rtl/water_pkg.sv
// Shared types and helpers for the lock-chamber water level controller.
package water_pkg;

    typedef enum logic [2:0] {
        ST_LOW   = 3'd0,
        ST_HIGH  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_RAISE = 3'd3,
        ST_LOWER = 3'd4
    } water_state_t;

    // Bits needed to hold max(a,b)-1, never less than one.
    function automatic int clog2_max(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = 0;
        while ((32'sd1 <<< w) < m) begin
            w = w + 32'sd1;
        end
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

endpackage

// File: rtl/water_level_ctrl_step_divider.sv
// Prescaler that emits a one-cycle step every `div` enabled clock cycles.
module step_divider #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             en,
    input  logic [DIV_W:0]   div,
    output logic             step
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = ({1'b0, r_cnt} == (div - (DIV_W+1)'(1)));
    // The step is not gated by clear so a step and a state change can share an edge.
    assign step   = en && w_last;

    // Prescaler counter: wraps on the last count, held at zero when cleared or idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= {DIV_W{1'b0}};
        end else if (clear || !en) begin
            r_cnt <= {DIV_W{1'b0}};
        end else if (w_last) begin
            r_cnt <= {DIV_W{1'b0}};
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/water_level_ctrl.sv
// Lock-chamber water level controller: level counter driven by raise/lower/stop
// commands at configurable fill and drain rates, with threshold flags and done pulse.
module water_level_ctrl
    import water_pkg::*;
#(
    parameter int LEVEL_MAX   = 50,
    parameter int RAISE_DIV   = 16,
    parameter int LOWER_DIV   = 14,
    parameter int HIGH_THRESH = 47,
    parameter int LOW_THRESH  = 3,
    localparam int LVL_W      = $clog2(LEVEL_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             w_up,
    input  logic             w_down,
    input  logic             w_stop,
    output logic [LVL_W-1:0] level,
    output logic             water_high,
    output logic             water_low,
    output logic             busy,
    output logic             done
);

    localparam int               DIV_W     = clog2_max(RAISE_DIV, LOWER_DIV);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(LEVEL_MAX);
    localparam logic [LVL_W-1:0] LVL_EMPTY = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_HI    = LVL_W'(HIGH_THRESH);
    localparam logic [LVL_W-1:0] LVL_LO    = LVL_W'(LOW_THRESH);
    localparam logic [DIV_W:0]   DIV_UP    = (DIV_W+1)'(RAISE_DIV);
    localparam logic [DIV_W:0]   DIV_DN    = (DIV_W+1)'(LOWER_DIV);

    water_state_t       r_state;
    water_state_t       w_state_nxt;
    logic [LVL_W-1:0]   r_level;
    logic [LVL_W-1:0]   w_level_nxt;
    logic               r_done;
    logic               w_cmd_up;
    logic               w_cmd_dn;
    logic               w_moving;
    logic               w_step;
    logic               w_clear;
    logic [DIV_W:0]     w_div;
    logic [LVL_W:0]     w_inc;
    logic [LVL_W:0]     w_dec;

    // Simultaneous up and down cancel; stop overrides both.
    assign w_cmd_up = w_up && !w_down && !w_stop;
    assign w_cmd_dn = w_down && !w_up && !w_stop;
    assign w_moving = (r_state == ST_RAISE) || (r_state == ST_LOWER);
    assign w_clear  = (w_state_nxt != r_state) || !w_moving;
    assign w_div    = (r_state == ST_LOWER) ? DIV_DN : DIV_UP;
    assign w_inc    = {1'b0, r_level} + (LVL_W+1)'(1);
    assign w_dec    = {1'b0, r_level} - (LVL_W+1)'(1);

    step_divider #(.DIV_W(DIV_W)) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_clear),
        .en      (w_moving),
        .div     (w_div),
        .step    (w_step)
    );

    // Saturating level update on a step edge.
    always_comb begin
        w_level_nxt = r_level;
        if (w_step && (r_state == ST_RAISE)) begin
            if (w_inc > {1'b0, LVL_FULL}) begin
                w_level_nxt = LVL_FULL;
            end else begin
                w_level_nxt = w_inc[LVL_W-1:0];
            end
        end else if (w_step && (r_state == ST_LOWER)) begin
            if (w_dec[LVL_W]) begin
                w_level_nxt = LVL_EMPTY;
            end else begin
                w_level_nxt = w_dec[LVL_W-1:0];
            end
        end else begin
            w_level_nxt = r_level;
        end
    end

    // Next-state decode; the step lands first, then stop/reversal, and stop beats arrival.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOW: begin
                if (w_cmd_up) w_state_nxt = ST_RAISE;
                else          w_state_nxt = ST_LOW;
            end
            ST_HIGH: begin
                if (w_cmd_dn) w_state_nxt = ST_LOWER;
                else          w_state_nxt = ST_HIGH;
            end
            ST_HOLD: begin
                if (w_cmd_up && (r_level != LVL_FULL))       w_state_nxt = ST_RAISE;
                else if (w_cmd_dn && (r_level != LVL_EMPTY)) w_state_nxt = ST_LOWER;
                else                                          w_state_nxt = ST_HOLD;
            end
            ST_RAISE: begin
                if (w_stop)                                      w_state_nxt = ST_HOLD;
                else if (w_cmd_dn)                               w_state_nxt = ST_LOWER;
                else if (w_step && (w_level_nxt == LVL_FULL))    w_state_nxt = ST_HIGH;
                else                                              w_state_nxt = ST_RAISE;
            end
            ST_LOWER: begin
                if (w_stop)                                      w_state_nxt = ST_HOLD;
                else if (w_cmd_up)                               w_state_nxt = ST_RAISE;
                else if (w_step && (w_level_nxt == LVL_EMPTY))   w_state_nxt = ST_LOW;
                else                                              w_state_nxt = ST_LOWER;
            end
            default: w_state_nxt = ST_LOW;
        endcase
    end

    // State, level and completion pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_LOW;
            r_level <= LVL_EMPTY;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_done  <= w_moving && ((w_state_nxt == ST_HIGH) || (w_state_nxt == ST_LOW));
        end
    end

    assign level      = r_level;
    assign water_high = (r_level >= LVL_HI);
    assign water_low  = (r_level <= LVL_LO);
    assign busy       = w_moving;
    assign done       = r_done;

endmodule

// File: tb/tb_water_level_ctrl.sv
// Directed bench for water_level_ctrl with LEVEL_MAX=10, RAISE_DIV=4, LOWER_DIV=3.
module tb_water_level_ctrl;

    logic       clk;
    logic       reset_n;
    logic       w_up;
    logic       w_down;
    logic       w_stop;
    logic [3:0] level;
    logic       water_high;
    logic       water_low;
    logic       busy;
    logic       done;

    int n_tests;
    int n_fail;

    water_level_ctrl #(
        .LEVEL_MAX   (10),
        .RAISE_DIV   (4),
        .LOWER_DIV   (3),
        .HIGH_THRESH (9),
        .LOW_THRESH  (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .w_up       (w_up),
        .w_down     (w_down),
        .w_stop     (w_stop),
        .level      (level),
        .water_high (water_high),
        .water_low  (water_low),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; w_up = 1'b0; w_down = 1'b0; w_stop = 1'b0;
        tick(2);
        n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_tests++; if ({water_low, water_high, busy, done} !== 4'b1000) begin n_fail++; $display("FAIL reset_flags: got low/high/busy/done=%b want 1000", {water_low, water_high, busy, done}); end
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_raise_full();
        w_up = 1'b1; tick(1); w_up = 1'b0;
        n_tests++; if (busy !== 1'b1 || level !== 4'd0) begin n_fail++; $display("FAIL raise_start: busy=%b level=%0d want 1,0", busy, level); end
        tick(3);
        n_tests++; if (level !== 4'd0) begin n_fail++; $display("FAIL raise_pre_step: level=%0d want 0", level); end
        tick(1);
        n_tests++; if (level !== 4'd1) begin n_fail++; $display("FAIL raise_first_step: level=%0d want 1", level); end
        tick(31);
        n_tests++; if (level !== 4'd8 || water_high !== 1'b0) begin n_fail++; $display("FAIL raise_lvl8: level=%0d high=%b want 8,0", level, water_high); end
        tick(1);
        n_tests++; if (level !== 4'd9 || water_high !== 1'b1) begin n_fail++; $display("FAIL raise_high_flag: level=%0d high=%b want 9,1", level, water_high); end
        tick(3);
        n_tests++; if (busy !== 1'b1 || done !== 1'b0 || level !== 4'd9) begin n_fail++; $display("FAIL raise_last_cycle: busy=%b done=%b level=%0d want 1,0,9", busy, done, level); end
        tick(1);
        n_tests++; if (level !== 4'd10 || busy !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL raise_end: level=%0d busy=%b done=%b want 10,0,1", level, busy, done); end
        tick(1);
        n_tests++; if (done !== 1'b0 || level !== 4'd10) begin n_fail++; $display("FAIL raise_done_pulse: done=%b level=%0d want 0,10", done, level); end
    endtask

    task automatic test_lower_full();
        w_down = 1'b1; tick(1); w_down = 1'b0;
        n_tests++; if (busy !== 1'b1 || water_high !== 1'b1) begin n_fail++; $display("FAIL lower_start: busy=%b high=%b want 1,1", busy, water_high); end
        tick(26);
        n_tests++; if (level !== 4'd2 || water_low !== 1'b0) begin n_fail++; $display("FAIL lower_lvl2: level=%0d low=%b want 2,0", level, water_low); end
        tick(1);
        n_tests++; if (level !== 4'd1 || water_low !== 1'b1) begin n_fail++; $display("FAIL lower_low_flag: level=%0d low=%b want 1,1", level, water_low); end
        tick(3);
        n_tests++; if (level !== 4'd0 || busy !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL lower_end: level=%0d busy=%b done=%b want 0,0,1", level, busy, done); end
        tick(1);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL lower_done_pulse: done=%b want 0", done); end
    endtask

    task automatic test_stop_hold();
        w_up = 1'b1; tick(1); w_up = 1'b0;
        tick(20);
        n_tests++; if (level !== 4'd5 || busy !== 1'b1) begin n_fail++; $display("FAIL hold_reach5: level=%0d busy=%b want 5,1", level, busy); end
        w_stop = 1'b1; tick(1); w_stop = 1'b0;
        n_tests++; if (level !== 4'd5 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL hold_entry: level=%0d busy=%b done=%b want 5,0,0", level, busy, done); end
        tick(5);
        n_tests++; if (level !== 4'd5 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL hold_stay: level=%0d busy=%b done=%b want 5,0,0", level, busy, done); end
        w_down = 1'b1; tick(1); w_down = 1'b0;
        tick(14);
        n_tests++; if (level !== 4'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL hold_lower_14: level=%0d busy=%b want 1,1", level, busy); end
        tick(1);
        n_tests++; if (level !== 4'd0 || done !== 1'b1) begin n_fail++; $display("FAIL hold_lower_end: level=%0d done=%b want 0,1", level, done); end
        tick(1);
    endtask

    task automatic test_reversal();
        w_up = 1'b1; tick(1); w_up = 1'b0;
        tick(24);
        n_tests++; if (level !== 4'd6) begin n_fail++; $display("FAIL rev_reach6: level=%0d want 6", level); end
        w_down = 1'b1; tick(1); w_down = 1'b0;
        n_tests++; if (level !== 4'd6 || busy !== 1'b1) begin n_fail++; $display("FAIL rev_enter: level=%0d busy=%b want 6,1", level, busy); end
        tick(2);
        n_tests++; if (level !== 4'd6) begin n_fail++; $display("FAIL rev_no_early: level=%0d want 6", level); end
        tick(1);
        n_tests++; if (level !== 4'd5) begin n_fail++; $display("FAIL rev_first_step: level=%0d want 5", level); end
        tick(15);
        n_tests++; if (level !== 4'd0 || done !== 1'b1) begin n_fail++; $display("FAIL rev_to_empty: level=%0d done=%b want 0,1", level, done); end
        tick(1);
    endtask

    task automatic test_both_cmds();
        w_up = 1'b1; w_down = 1'b1; tick(3);
        n_tests++; if (busy !== 1'b0 || level !== 4'd0) begin n_fail++; $display("FAIL both_cmds: busy=%b level=%0d want 0,0", busy, level); end
        w_up = 1'b0; w_down = 1'b0; tick(1);
    endtask

    task automatic test_reset_mid();
        w_up = 1'b1; tick(1); w_up = 1'b0;
        tick(16);
        n_tests++; if (level !== 4'd4) begin n_fail++; $display("FAIL rst_mid_reach4: level=%0d want 4", level); end
        reset_n = 1'b0; #1;
        n_tests++; if (level !== 4'd0 || {water_low, water_high, busy, done} !== 4'b1000) begin n_fail++; $display("FAIL rst_mid_async: level=%0d low/high/busy/done=%b want 0,1000", level, {water_low, water_high, busy, done}); end
        tick(1); reset_n = 1'b1;
        tick(2);
        n_tests++; if (level !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after: level=%0d busy=%b done=%b want 0,0,0", level, busy, done); end
    endtask

    task automatic test_stop_at_end();
        w_up = 1'b1; tick(1); w_up = 1'b0;
        tick(39);
        n_tests++; if (level !== 4'd9 || busy !== 1'b1) begin n_fail++; $display("FAIL stop_end_pre: level=%0d busy=%b want 9,1", level, busy); end
        w_stop = 1'b1; tick(1); w_stop = 1'b0;
        n_tests++; if (level !== 4'd10 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL stop_end_hold: level=%0d busy=%b done=%b want 10,0,0", level, busy, done); end
        w_up = 1'b1; tick(2); w_up = 1'b0;
        n_tests++; if (busy !== 1'b0 || level !== 4'd10 || done !== 1'b0) begin n_fail++; $display("FAIL stop_end_up_ignored: busy=%b level=%0d done=%b want 0,10,0", busy, level, done); end
        w_down = 1'b1; tick(1); w_down = 1'b0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stop_end_down: busy=%b want 1", busy); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_raise_full();
        test_lower_full();
        test_stop_hold();
        test_reversal();
        test_both_cmds();
        test_reset_mid();
        test_stop_at_end();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/water_level_ctrl.md
# water_level_ctrl

Parametrised lock-chamber water level controller that replaces the fixed two-timer raise/lower FSM. It tracks the chamber level as an explicit counter, moving it at configurable fill and drain rates. It supports stop/hold at any level and reversal of direction mid-motion. It reports level-threshold flags and a completion pulse. It sits between the lock sequencing FSM (which issues `w_up`/`w_down`/`w_stop`) and the gate-interlock logic (which consumes `water_high`/`water_low`).

## Interface
- `LEVEL_MAX`, 50: full-chamber level in counter units (0.1 ft); empty is 0.
- `RAISE_DIV`, 16: clock cycles per +1 level step while raising; must be ≥1.
- `LOWER_DIV`, 14: clock cycles per −1 level step while lowering; must be ≥1.
- `HIGH_THRESH`, 47: `water_high` asserts when level ≥ this value.
- `LOW_THRESH`, 3: `water_low` asserts when level ≤ this value.
- Derived: `LVL_W = $clog2(LEVEL_MAX+1)`; `DIV_W = $clog2(max(RAISE_DIV,LOWER_DIV))`, minimum 1.
- `clk`  in  1  single system clock; all state is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `w_up`  in  1  request raise (level-sensitive, sampled each cycle).
- `w_down`  in  1  request lower.
- `w_stop`  in  1  halt at the current level.
- `level`  out  LVL_W  current level.
- `water_high`  out  1  level ≥ HIGH_THRESH.
- `water_low`  out  1  level ≤ LOW_THRESH.
- `busy`  out  1  high in RAISE or LOWER.
- `done`  out  1  one-cycle pulse when a motion ends at LEVEL_MAX or 0.

## Operation
- States: LOW (level=0, idle), HIGH (level=LEVEL_MAX, idle), HOLD (idle at intermediate level), RAISE, LOWER.
- Command decode each cycle, in priority order:
  - `w_stop` overrides all.
  - `w_up` together with `w_down` (without `w_stop`) is treated as no command.
  - Otherwise the single asserted request applies.
- LOW: `w_up` → RAISE; all other commands are ignored.
- HIGH: `w_down` → LOWER; all other commands are ignored.
- HOLD:
  - `w_up` → RAISE unless level=LEVEL_MAX.
  - `w_down` → LOWER unless level=0.
  - Otherwise stay.
- RAISE:
  - `w_stop` → HOLD.
  - `w_down` → LOWER (reversal).
  - Step edge that makes level=LEVEL_MAX → HIGH.
- LOWER:
  - `w_stop` → HOLD.
  - `w_up` → RAISE (reversal).
  - Step edge that makes level=0 → LOW.
- Prescaler:
  - Cleared to 0 on every state change and in idle states.
  - In RAISE it counts 0..RAISE_DIV−1; on the edge where it equals RAISE_DIV−1 it wraps to 0 and level increments.
  - LOWER behaves the same with LOWER_DIV, and level decrements.
- Level saturates: never exceeds LEVEL_MAX and never wraps below 0. Step arithmetic is done at LVL_W+1 bits and then compared.
- Reversal or stop on the same edge as a step: the step is applied first, then the command takes effect. Stop wins over reaching an end: stop on the final step edge goes to HOLD at LEVEL_MAX or 0. HOLD at those levels only accepts the opposite direction.
- `water_high`, `water_low` and `busy` are decoded combinationally from the registered `level` and state.
- `done` is registered: high for exactly the first cycle in HIGH or LOW entered from RAISE or LOWER. It is not asserted after reset and not on HOLD entry.

## Timing
- Reset values (asynchronous): state LOW, `level`=0, prescaler 0, `water_low`=1, `water_high`=0, `busy`=0, `done`=0.
- Reset asserted mid-motion aborts immediately to the reset values; no `done` is generated.
- Command sampled at edge k → new state visible after edge k; `busy` rises the same cycle.
- First level step occurs DIV edges after entering RAISE or LOWER.
- A full raise from 0 spends LEVEL_MAX·RAISE_DIV cycles in RAISE. A full lower spends LEVEL_MAX·LOWER_DIV cycles in LOWER.
- `done` is asserted in the first cycle after the end state is entered, coincident with `busy`=0.

## Structure
- `water_pkg`: state enum typedef `water_state_t` {LOW, HIGH, HOLD, RAISE, LOWER} and a shared clog2/max helper function.
- Sub-module `step_divider`:
  - Parameter DIV_W.
  - Inputs: `clk`, `reset_n`, `clear`, `en`, `div` (DIV_W+1 bits).
  - Output: `step` pulse.
  - Instantiated once, with `div` muxed by direction.
- Top contains the FSM, the level register and the output decode.

## Test plan
All scenarios use LEVEL_MAX=10, RAISE_DIV=4, LOWER_DIV=3, HIGH_THRESH=9, LOW_THRESH=1.
- Reset, then one-cycle `w_up` → RAISE; level reaches 1 after 4 cycles and 10 after 40 cycles. `water_high` rises at level 9; state HIGH; `done` is high for 1 cycle; `busy`=0.
- From HIGH, `w_down` → level 0 after 30 cycles. `water_low` rises at level 1; state LOW; single `done` pulse.
- Raise to level 5, pulse `w_stop` → HOLD at 5 with no `done`. Then `w_down` → reaches 0 after 15 cycles.
- Raise to level 6, pulse `w_down` → prescaler clears; level 5 after 3 cycles; no level skip.
- `w_up`+`w_down` together in LOW → no state change. `reset_n` pulsed low mid-raise at level 4 → level 0, LOW, all outputs at reset values immediately.
